// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared pipeline definitions for the MEM/WB writeback bundle and the register file.
package wb_regfile_scoreboard_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        word_t    result;
        reg_idx_t rd;
        logic     wren;
    } wb_bundle_t;

endpackage

// File: rtl/wb_regfile_scoreboard_reg_scoreboard.sv
// Pending-write tracker: busy bits, hazard stall and a registered count of busy registers.
module wb_regfile_scoreboard_reg_scoreboard
    import wb_regfile_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_wren,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              issue_valid,
    input  logic              issue_wren,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              src1_used,
    input  logic              src2_used,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_eff;
    logic [ADDR_W:0]  count_q;
    logic             clr_en;
    logic             set_en;
    logic             inc;
    logic             dec;

    // A register being written back this cycle no longer blocks its consumers.
    always_comb begin
        busy_eff = busy_q;
        if (wb_wren) busy_eff[wb_rd] = 1'b0;
    end

    assign stall = issue_valid && ((src1_used && busy_eff[rs1_addr]) ||
                                   (src2_used && busy_eff[rs2_addr]) ||
                                   (issue_wren && busy_eff[issue_rd]));

    assign clr_en = wb_wren && (wb_rd != '0);
    assign set_en = issue_valid && !stall && issue_wren && (issue_rd != '0);

    // Set after clear so a new producer wins over the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[wb_rd] = 1'b0;
        if (set_en) busy_d[issue_rd] = 1'b1;
    end

    assign inc = set_en && !busy_q[issue_rd];
    assign dec = clr_en && busy_q[wb_rd] && !(set_en && (issue_rd == wb_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q <= busy_d;
            case ({inc, dec})
                2'b10:   count_q <= count_q + {{ADDR_W{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{ADDR_W{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

    assign busy_count = count_q;

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Writeback consumer: architectural register file with write-through read ports and
// a scoreboard that stalls decode on RAW/WAW hazards.
module wb_regfile_scoreboard
    import wb_regfile_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_wren,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              issue_valid,
    input  logic              issue_wren,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              src1_used,
    input  logic              src2_used,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    word_t      regs [NREGS];
    wb_bundle_t wb;
    logic       commit;

    assign wb     = '{result: wb_result, rd: wb_rd, wren: wb_wren};
    assign commit = wb.wren && (wb.rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (commit) begin
            regs[wb.rd] <= wb.result;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0) rs1_data = '0;
        else if (wb.wren && (wb.rd == rs1_addr)) rs1_data = wb.result;
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0) rs2_data = '0;
        else if (wb.wren && (wb.rd == rs2_addr)) rs2_data = wb.result;
    end

    wb_regfile_scoreboard_reg_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_wren     (wb.wren),
        .wb_rd       (wb.rd),
        .issue_valid (issue_valid),
        .issue_wren  (issue_wren),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .src1_used   (src1_used),
        .src2_used   (src2_used),
        .stall       (stall),
        .busy_count  (busy_count)
    );

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor compares at negedge.
module tb_wb_regfile_scoreboard;

    typedef struct packed {
        logic [31:0] res;
        logic [6:0]  wbrd;
        logic        wbw;
        logic [6:0]  a1;
        logic [6:0]  a2;
        logic        iv;
        logic        iw;
        logic [6:0]  ird;
        logic        u1;
        logic        u2;
    } stim_t;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        st;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_result;
    logic [6:0]  wb_rd;
    logic        wb_wren;
    logic [6:0]  rs1_addr;
    logic [6:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid;
    logic        issue_wren;
    logic [6:0]  issue_rd;
    logic        src1_used;
    logic        src2_used;
    logic        stall;
    logic [7:0]  busy_count;

    int checks = 0;
    int errors = 0;

    exp_t  exp_q [$];
    string name_q [$];

    // Reference model: plain arrays of register values and pending-write flags.
    logic [31:0] m_regs [128];
    bit          m_busy [128];
    stim_t       cur;

    wb_regfile_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_result   (wb_result),
        .wb_rd       (wb_rd),
        .wb_wren     (wb_wren),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_valid (issue_valid),
        .issue_wren  (issue_wren),
        .issue_rd    (issue_rd),
        .src1_used   (src1_used),
        .src2_used   (src2_used),
        .stall       (stall),
        .busy_count  (busy_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit m_hazard(input logic [6:0] r, input stim_t s);
        return m_busy[r] && !(s.wbw && s.wbrd == r);
    endfunction

    function automatic bit m_stall(input stim_t s);
        if (!s.iv) return 1'b0;
        return (s.u1 && m_hazard(s.a1, s)) || (s.u2 && m_hazard(s.a2, s)) ||
               (s.iw && m_hazard(s.ird, s));
    endfunction

    function automatic logic [31:0] m_read(input logic [6:0] a, input stim_t s);
        if (a == 0) return 32'h0;
        if (s.wbw && s.wbrd == a) return s.res;
        return m_regs[a];
    endfunction

    function automatic logic [7:0] m_count();
        int n = 0;
        for (int r = 0; r < 128; r++) if (m_busy[r]) n++;
        return 8'(n);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 128; r++) begin
            m_regs[r] = 32'h0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_step(input stim_t s);
        bit issued;
        issued = s.iv && !m_stall(s);
        if (s.wbw && s.wbrd != 0) begin
            m_regs[s.wbrd] = s.res;
            m_busy[s.wbrd] = 1'b0;
        end
        if (issued && s.iw && s.ird != 0) m_busy[s.ird] = 1'b1;
    endtask

    task automatic drive(input stim_t s);
        wb_result   = s.res;
        wb_rd       = s.wbrd;
        wb_wren     = s.wbw;
        rs1_addr    = s.a1;
        rs2_addr    = s.a2;
        issue_valid = s.iv;
        issue_wren  = s.iw;
        issue_rd    = s.ird;
        src1_used   = s.u1;
        src2_used   = s.u2;
    endtask

    // One cycle: retire the previous cycle into the model, optionally pulse reset, then drive.
    task automatic apply(input stim_t s, input string name, input bit do_rst);
        exp_t e;
        @(posedge clk);
        #1;
        model_step(cur);
        if (do_rst) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            rst_n = 1'b1;
        end
        cur = s;
        drive(s);
        e.r1  = m_read(s.a1, s);
        e.r2  = m_read(s.a2, s);
        e.st  = m_stall(s);
        e.cnt = m_count();
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check({n, ".rs1_data"}, rs1_data, e.r1);
            check({n, ".rs2_data"}, rs2_data, e.r2);
            check({n, ".stall"}, {31'h0, stall}, {31'h0, e.st});
            check({n, ".busy_count"}, {24'h0, busy_count}, {24'h0, e.cnt});
        end
    end

    function automatic logic [6:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return 7'($urandom_range(0, 127));
        return 7'($urandom_range(0, 7));
    endfunction

    initial begin
        stim_t s;
        rst_n = 1'b0;
        cur   = idle();
        drive(cur);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        s = idle(); s.a1 = 7'd5;
        apply(s, "reset_read", 1'b0);
        s = idle(); s.wbw = 1; s.wbrd = 7'd5; s.res = 32'hDEADBEEF; s.a1 = 7'd5;
        apply(s, "bypass", 1'b0);
        s = idle(); s.a1 = 7'd5;
        apply(s, "committed", 1'b0);

        s = idle(); s.iv = 1; s.iw = 1; s.ird = 7'd9;
        apply(s, "issue_rd9", 1'b0);
        s = idle(); s.iv = 1; s.a2 = 7'd9; s.u2 = 1;
        apply(s, "raw_stall", 1'b0);
        s.wbw = 1; s.wbrd = 7'd9; s.res = 32'h12;
        apply(s, "raw_release", 1'b0);

        s = idle(); s.iv = 1; s.iw = 1; s.ird = 7'd9;
        apply(s, "reissue_rd9", 1'b0);
        apply(s, "waw_stall", 1'b0);
        s.wbw = 1; s.wbrd = 7'd9; s.res = 32'h34;
        apply(s, "waw_with_wb", 1'b0);
        s = idle(); s.wbw = 1; s.wbrd = 7'd9; s.res = 32'h56; s.a1 = 7'd9;
        apply(s, "waw_count", 1'b0);

        s = idle(); s.wbw = 1; s.wbrd = 7'd0; s.res = 32'hFFFFFFFF; s.a1 = 7'd0;
        s.iv = 1; s.iw = 1; s.ird = 7'd0;
        apply(s, "reg0_write", 1'b0);
        s = idle(); s.a1 = 7'd0; s.a2 = 7'd9;
        apply(s, "reg0_read", 1'b0);

        s = idle(); s.iv = 1; s.iw = 1; s.ird = 7'd3;
        apply(s, "issue_rd3", 1'b0);
        s.ird = 7'd4;
        apply(s, "issue_rd4", 1'b0);
        s = idle(); s.iv = 1; s.u1 = 1; s.a1 = 7'd3;
        apply(s, "after_reset", 1'b1);
        s = idle(); s.wbw = 1; s.wbrd = 7'd3; s.res = 32'hABC; s.a1 = 7'd3;
        apply(s, "post_reset_wb", 1'b0);
        s = idle(); s.a1 = 7'd3;
        apply(s, "post_reset_read", 1'b0);

        for (int i = 0; i < 400; i++) begin
            s      = idle();
            s.wbw  = ($urandom_range(0, 2) == 0);
            s.wbrd = rnd_reg();
            s.res  = $urandom;
            s.a1   = rnd_reg();
            s.a2   = rnd_reg();
            s.iv   = ($urandom_range(0, 3) != 0);
            s.iw   = ($urandom_range(0, 1) == 0);
            s.ird  = rnd_reg();
            s.u1   = $urandom_range(0, 1);
            s.u2   = $urandom_range(0, 1);
            apply(s, "random", ($urandom_range(0, 99) == 0));
        end

        s = idle();
        apply(s, "drain", 1'b0);
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
